// File: rtl/univ_shift_reg_if.sv
// Bundle for the universal shift register: mode/data/serial in, state out.
// UNIV_SHIFT_ROTATE_EN adds the sin_sel rotate select.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
`ifdef UNIV_SHIFT_ROTATE_EN
  logic             sin_sel;
`endif
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qb;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             done;

`ifdef UNIV_SHIFT_ROTATE_EN
  modport master (
    output mode, d, sin, sin_sel,
    input  Q, Qb, sout, cnt, done
  );

  modport slave (
    input  mode, d, sin, sin_sel,
    output Q, Qb, sout, cnt, done
  );
`else
  modport master (
    output mode, d, sin,
    input  Q, Qb, sout, cnt, done
  );

  modport slave (
    input  mode, d, sin,
    output Q, Qb, sout, cnt, done
  );
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift left / shift right / load, with shift count.
// UNIV_SHIFT_ROTATE_EN lets sin_sel recirculate the outgoing bit (rotate).
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  univ_shift_reg_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    M_HOLD  = 2'b00,
    M_LEFT  = 2'b01,
    M_RIGHT = 2'b10,
    M_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             shift;
  logic             in_l;
  logic             in_r;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

`ifdef UNIV_SHIFT_ROTATE_EN
  assign in_l = bus.sin_sel ? q_q[WIDTH-1] : bus.sin;
  assign in_r = bus.sin_sel ? q_q[0]       : bus.sin;
`else
  assign in_l = bus.sin;
  assign in_r = bus.sin;
`endif

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;

    unique case (mode)
      M_HOLD: begin
        q_d = q_q;
      end
      M_LEFT: begin
        q_d    = {q_q[WIDTH-2:0], in_l};
        sout_d = q_q[WIDTH-1];
        shift  = 1'b1;
      end
      M_RIGHT: begin
        q_d    = {in_r, q_q[WIDTH-1:1]};
        sout_d = q_q[0];
        shift  = 1'b1;
      end
      M_LOAD: begin
        q_d   = bus.d;
        cnt_d = '0;
      end
    endcase

    // Saturating count; done only on the WIDTH-1 -> WIDTH step.
    if (shift) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      done_d = (cnt_q == CNT_LAST);
    end

    qb_d = ~q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      qb_q   <= ~RST_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      qb_q   <= qb_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Qb   = qb_q;
  assign bus.sout = sout_q;
  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with an arithmetic reference model.
// Define UNIV_SHIFT_ROTATE_EN to exercise the rotate select.
module tb_univ_shift_reg;
  localparam int W    = 8;
  localparam int CW   = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(
    .WIDTH  (W),
    .RST_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as a plain integer.
  int m_q;
  int m_sout;
  int m_cnt;
  int m_done;

  always @(posedge clk or negedge rst_n) begin
    int nq, ns, nc, nd, outb, inb, rot;
    if (!rst_n) begin
      m_q    <= 0;
      m_sout <= 0;
      m_cnt  <= 0;
      m_done <= 0;
    end else begin
      nq = m_q; ns = m_sout; nc = m_cnt; nd = 0;
      rot = 0;
`ifdef UNIV_SHIFT_ROTATE_EN
      rot = int'(bus.sin_sel);
`endif
      if (bus.mode == 2'd1 || bus.mode == 2'd2) begin
        if (bus.mode == 2'd1) begin
          outb = (m_q / (1 << (W - 1))) % 2;
          inb  = rot ? outb : int'(bus.sin);
          nq   = ((m_q * 2) + inb) & MASK;
        end else begin
          outb = m_q % 2;
          inb  = rot ? outb : int'(bus.sin);
          nq   = (m_q / 2) + inb * (1 << (W - 1));
        end
        ns = outb;
        nd = (m_cnt == W - 1) ? 1 : 0;
        nc = (m_cnt + 1 > W) ? W : m_cnt + 1;
      end else if (bus.mode == 2'd3) begin
        nq = int'(bus.d);
        nc = 0;
      end
      m_q    <= nq;
      m_sout <= ns;
      m_cnt  <= nc;
      m_done <= nd;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_Q", int'(bus.Q), m_q);
      chk("model_Qb", int'(bus.Qb), (~m_q) & MASK);
      chk("model_sout", int'(bus.sout), m_sout);
      chk("model_cnt", int'(bus.cnt), m_cnt);
      chk("model_done", int'(bus.done), m_done);
    end
  end

  // Drive at posedge+2, return at the following posedge+2.
  task automatic step(input logic [1:0] m, input logic [7:0] dv, input logic s);
    bus.mode = m;
    bus.d    = dv;
    bus.sin  = s;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] ser_exp;
  logic [7:0] des_in;

  initial begin
    checks    = 0;
    errors    = 0;
    ser_exp   = 8'b1010_0101;
    des_in    = 8'b0101_0011;
    bus.mode  = 2'd0;
    bus.d     = '0;
    bus.sin   = 1'b0;
`ifdef UNIV_SHIFT_ROTATE_EN
    bus.sin_sel = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_Q", int'(bus.Q), 8'h00);
    chk("rst_Qb", int'(bus.Qb), 8'hFF);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_sout", int'(bus.sout), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Load then hold.
    step(2'd3, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step(2'd0, 8'h00, 1'b1);
    chk("hold_Q", int'(bus.Q), 8'hA5);
    chk("hold_Qb", int'(bus.Qb), 8'h5A);
    chk("hold_cnt", int'(bus.cnt), 0);
    chk("hold_done", int'(bus.done), 0);

    // Serialize MSB first.
    step(2'd3, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(2'd1, 8'h00, 1'b0);
      chk("ser_sout", int'(bus.sout), int'(ser_exp[7-i]));
      chk("ser_cnt", int'(bus.cnt), i + 1);
      chk("ser_done", int'(bus.done), (i == 7) ? 1 : 0);
    end
    chk("ser_Q", int'(bus.Q), 8'h00);
    step(2'd1, 8'h00, 1'b0);
    chk("sat_cnt", int'(bus.cnt), 8);
    chk("sat_done", int'(bus.done), 0);

    // Deserialize from the left end.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(2'd2, 8'h00, des_in[i]);
      chk("des_done", int'(bus.done), (i == 7) ? 1 : 0);
    end
    chk("des_Q", int'(bus.Q), 8'h53);
    step(2'd0, 8'h00, 1'b0);
    chk("des_done_off", int'(bus.done), 0);

    // Reset in the middle of a sequence.
    step(2'd3, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) step(2'd1, 8'h00, 1'b0);
    chk("mid_cnt4", int'(bus.cnt), 4);
    chk("mid_Q", int'(bus.Q), 8'hF0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_Q", int'(bus.Q), 8'h00);
    chk("mid_rst_Qb", int'(bus.Qb), 8'hFF);
    chk("mid_rst_cnt", int'(bus.cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(2'd1, 8'h00, 1'b1);
      chk("mid_done", int'(bus.done), (i == 7) ? 1 : 0);
    end
    chk("mid_fill_Q", int'(bus.Q), 8'hFF);

    // Mixed directions still count.
    step(2'd3, 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 2'd1 : 2'd2, 8'h00, 1'b0);
      chk("mix_done", int'(bus.done), (i == 7) ? 1 : 0);
    end
    chk("mix_cnt", int'(bus.cnt), 8);

    // Rotate select, or plain shift when absent.
    step(2'd3, 8'h81, 1'b0);
`ifdef UNIV_SHIFT_ROTATE_EN
    bus.sin_sel = 1'b1;
    step(2'd1, 8'h00, 1'b0);
    chk("rot_Q", int'(bus.Q), 8'h03);
    chk("rot_sout", int'(bus.sout), 1);
    step(2'd2, 8'h00, 1'b0);
    chk("rotr_Q", int'(bus.Q), 8'h81);
    bus.sin_sel = 1'b0;
`else
    step(2'd1, 8'h00, 1'b0);
    chk("norot_Q", int'(bus.Q), 8'h02);
    chk("norot_sout", int'(bus.sout), 1);
`endif
    step(2'd0, 8'h00, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register built on D flip-flops. It is the successor to the team's single-bit D flip-flop with Q/Qb outputs. It adds WIDTH-bit storage, four operating modes (hold, shift left, shift right, parallel load), serial in/out, and a shift counter with a done pulse. It serves as the building block for serializer/deserializer and synchronizer stages in later labs.

Parameters:
WIDTH, 8, number of flip-flops (data width); legal range 2..32.
RST_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
d  input  WIDTH  parallel load data
sin  input  1  serial input bit
Q  output  WIDTH  register contents
Qb  output  WIDTH  bitwise complement of Q
sout  output  1  bit shifted out on the most recent shift
cnt  output  $clog2(WIDTH+1)  shifts completed since the last load or reset
done  output  1  one-cycle pulse when cnt reaches WIDTH

Behaviour:
- Interface: one clock, clk, rising edge. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately and independent of clk): Q=RST_VAL, Qb=~RST_VAL, sout=0, cnt=0, done=0.
- Deassertion of rst_n is synchronous to the next clk edge: the first update occurs on the first rising edge with rst_n=1.
- Reset asserted mid-operation aborts any shift sequence. No partial state survives.
- All updates occur on the rising clk edge, 1-cycle latency. Inputs are sampled at the edge.
- Qb always equals ~Q. It is registered alongside Q, not derived by a combinational inverter after the flops.
- mode 00 (hold): Q, sout and cnt are unchanged; done=0.
- mode 01 (shift left): Q <= {Q[WIDTH-2:0], sin}; sout <= Q[WIDTH-1].
- mode 10 (shift right): Q <= {sin, Q[WIDTH-1:1]}; sout <= Q[0].
- mode 11 (load): Q <= d; sout unchanged; cnt <= 0; done=0.
- Counter on each shift (01/10):
  - if cnt < WIDTH, cnt <= cnt+1;
  - if cnt = WIDTH, cnt saturates at WIDTH.
- done is 1 for exactly the cycle after the edge at which cnt transitions WIDTH-1 -> WIDTH. Otherwise done is 0.
- Further shifts at saturation never re-pulse done. Only a load or a reset re-arms it.
- Mixed-direction shifts each count as one shift.
- mode changes take effect on the next edge. No mode is illegal.
- Data and mode must meet the flop setup/hold requirements. Behaviour on a violation is simulation-X and is not specified further.

Optional Feature:
Macro: UNIV_SHIFT_ROTATE_EN.
- Defined: when sin_sel (an extra 1-bit input port present only with the macro) is 1, the serial input becomes the outgoing bit, making the shift a rotate:
  - left rotate: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
  - right rotate: Q <= {Q[0], Q[WIDTH-1:1]}.
  - sout and cnt behave as for a normal shift.
- sin_sel=0 gives normal shift behaviour.
- Not defined: the sin_sel port does not exist, and behaviour is exactly as specified above.

Test Plan:
- Reset: hold rst_n=0 mid-cycle between edges -> Q=0x00, Qb=0xFF, cnt=0 immediately, without waiting for a clk edge.
- Load then hold: mode=11, d=0xA5, one edge; then mode=00 for 3 edges -> Q=0xA5 and Qb=0x5A stable, cnt=0, done=0.
- Shift-left serialize: load 0xA5; mode=01, sin=0 for 8 edges:
  - sout sequence 1,0,1,0,0,1,0,1; Q=0x00 at the end;
  - cnt 1..8; done high only in the cycle after the 8th edge;
  - a 9th shift leaves cnt=8 with no new done pulse.
- Shift-right deserialize: reset, mode=10, sin pattern 1,1,0,0,1,0,1,0 over 8 edges -> Q=0x53, done pulses once.
- Reset mid-sequence: load 0xFF, 4 left shifts (cnt=4), pulse rst_n low between edges -> Q=0x00 and cnt=0 at once. The next 8 shifts produce done after the 8th, not the 4th.
- With UNIV_SHIFT_ROTATE_EN: load 0x81, sin_sel=1, mode=01 one edge -> Q=0x03, sout=1. Without the macro, the bench confirms the sin_sel port is absent and the same stimulus with sin=0 gives Q=0x02.
